// File: rtl/decode_branch.sv
// Decode-stage branch resolution: IF/ID pipeline register, beq/bne/j target
// and redirect generation toward fetch, wrong-path squash and a redirect counter.
module decode_branch #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = '0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instructionf,
  input  logic [WIDTH-1:0] pc_plus_4f,
  input  logic             stall_d,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0] alu_out_m,
  input  logic             forward_ad,
  input  logic             forward_bd,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_plus_4d,
  output logic             valid_d,
  output logic [4:0]       rs_d,
  output logic [4:0]       rt_d,
  output logic [4:0]       rd_d,
  output logic [WIDTH-1:0] pc_branch_d,
  output logic             pcsrc_d,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [5:0] {
    OP_J   = 6'b000010,
    OP_BEQ = 6'b000100,
    OP_BNE = 6'b000101
  } opcode_e;

  logic [5:0]       op;
  logic             is_beq, is_bne, is_j;
  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic             eq;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;
  logic             taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d     <= NOP_INSTR;
      pc_plus_4d  <= '0;
      valid_d     <= 1'b0;
      taken_count <= '0;
    end else begin
      if (pcsrc_d)
        taken_count <= taken_count + CNT_W'(1);
      // pcsrc_d is already gated by stall_d, so flush never meets a held register
      if (!stall_d) begin
        pc_plus_4d <= pc_plus_4f;
        if (pcsrc_d) begin
          instr_d <= NOP_INSTR;
          valid_d <= 1'b0;
        end else begin
          instr_d <= instructionf;
          valid_d <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    op     = instr_d[31:26];
    is_beq = (op == OP_BEQ);
    is_bne = (op == OP_BNE);
    is_j   = (op == OP_J);

    rs_d = instr_d[25:21];
    rt_d = instr_d[20:16];
    rd_d = instr_d[15:11];

    cmp_a = forward_ad ? alu_out_m : rd1_d;
    cmp_b = forward_bd ? alu_out_m : rd2_d;
    eq    = (cmp_a == cmp_b);

    imm_ext       = {{(WIDTH-16){instr_d[15]}}, instr_d[15:0]};
    branch_target = pc_plus_4d + (imm_ext << 2);
    jump_target   = {pc_plus_4d[WIDTH-1:WIDTH-4], instr_d[25:0], 2'b00};

    pc_branch_d = is_j ? jump_target : branch_target;
    taken       = (is_beq & eq) | (is_bne & ~eq) | is_j;
    pcsrc_d     = taken & valid_d & ~stall_d;
  end

endmodule

// File: tb/tb_decode_branch.sv
// Bench for decode_branch: directed scenarios followed by random traffic,
// compared against a cycle-level behavioural model of the decode stage.
module tb_decode_branch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instructionf = '0, pc_plus_4f = '0;
  logic        stall_d = 1'b0;
  logic [31:0] rd1_d = '0, rd2_d = '0, alu_out_m = '0;
  logic        forward_ad = 1'b0, forward_bd = 1'b0;

  logic [31:0] instr_d, pc_plus_4d, pc_branch_d;
  logic        valid_d, pcsrc_d;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic [15:0] taken_count;

  logic [31:0] instr_w, pc4_w, pcb_w;
  logic        valid_w, pcsrc_w;
  logic [4:0]  rs_w, rt_w, rd_w;
  logic [1:0]  cnt_w;

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;
  int          m_cnt;

  decode_branch dut (
    .clk(clk), .reset(reset), .instructionf(instructionf), .pc_plus_4f(pc_plus_4f),
    .stall_d(stall_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .alu_out_m(alu_out_m),
    .forward_ad(forward_ad), .forward_bd(forward_bd), .instr_d(instr_d),
    .pc_plus_4d(pc_plus_4d), .valid_d(valid_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .pc_branch_d(pc_branch_d), .pcsrc_d(pcsrc_d), .taken_count(taken_count)
  );

  decode_branch #(.CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .instructionf(instructionf), .pc_plus_4f(pc_plus_4f),
    .stall_d(stall_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .alu_out_m(alu_out_m),
    .forward_ad(forward_ad), .forward_bd(forward_bd), .instr_d(instr_w),
    .pc_plus_4d(pc4_w), .valid_d(valid_w), .rs_d(rs_w), .rt_d(rt_w), .rd_d(rd_w),
    .pc_branch_d(pcb_w), .pcsrc_d(pcsrc_w), .taken_count(cnt_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_redirect();
    logic [31:0] a, b;
    a = forward_ad ? alu_out_m : rd1_d;
    b = forward_bd ? alu_out_m : rd2_d;
    case (m_instr[31:26])
      6'd2:    return m_valid && !stall_d;
      6'd4:    return (a == b) && m_valid && !stall_d;
      6'd5:    return (a != b) && m_valid && !stall_d;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_target();
    int signed offs;
    if (m_instr[31:26] == 6'd2)
      return (m_pc4 & 32'hF000_0000) | (m_instr & 32'h03FF_FFFF) * 4;
    offs = int'($signed(m_instr[15:0])) * 4;
    return m_pc4 + 32'(offs);
  endfunction

  task automatic check_all(input string tag);
    logic        e_src;
    logic [31:0] e_tgt;
    e_src = model_redirect();
    e_tgt = model_target();
    check({tag, ".instr"},  instr_d,     m_instr);
    check({tag, ".pc4"},    pc_plus_4d,  m_pc4);
    check({tag, ".valid"},  32'(valid_d), 32'(m_valid));
    check({tag, ".rs"},     32'(rs_d),   32'((m_instr >> 21) & 31));
    check({tag, ".rt"},     32'(rt_d),   32'((m_instr >> 16) & 31));
    check({tag, ".rd"},     32'(rd_d),   32'((m_instr >> 11) & 31));
    check({tag, ".target"}, pc_branch_d, e_tgt);
    check({tag, ".pcsrc"},  32'(pcsrc_d), 32'(e_src));
    check({tag, ".count"},  32'(taken_count), 32'(m_cnt % 65536));
    check({tag, ".w.instr"}, instr_w, m_instr);
    check({tag, ".w.pc4"},   pc4_w,   m_pc4);
    check({tag, ".w.valid"}, 32'(valid_w), 32'(m_valid));
    check({tag, ".w.rsrtrd"}, {17'd0, rs_w, rt_w, rd_w}, {17'd0, m_instr[25:11]});
    check({tag, ".w.target"}, pcb_w, e_tgt);
    check({tag, ".w.pcsrc"},  32'(pcsrc_w), 32'(e_src));
    check({tag, ".w.count"},  32'(cnt_w), 32'(m_cnt % 4));
  endtask

  task automatic model_reset();
    m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_cnt = 0;
  endtask

  // advance one rising edge, updating the model with the inputs in force at it
  task automatic tick();
    logic src;
    src = model_redirect();
    @(posedge clk);
    if (reset) model_reset();
    else begin
      if (src) m_cnt++;
      if (!stall_d) begin
        m_pc4 = pc_plus_4f;
        if (src) begin m_instr = '0; m_valid = 1'b0; end
        else begin m_instr = instructionf; m_valid = 1'b1; end
      end
    end
    #1;
  endtask

  task automatic load(input logic [31:0] ins, input logic [31:0] pc4);
    instructionf = ins; pc_plus_4f = pc4; stall_d = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] r;
    logic [5:0]  op;

    // power-up reset
    #1 reset = 1'b1;
    #1 model_reset();
    check_all("por");
    tick();
    reset = 1'b0;
    #1 check_all("post_por");

    // some traffic, then reset in the middle of a cycle with no edge
    load(32'h012A4020, 32'h0000_0010);
    load(32'h08000004, 32'h0000_0014);
    check_all("pre_reset");
    #2 reset = 1'b1;
    #1 model_reset();
    check("t1.instr", instr_d, 32'h0);
    check("t1.valid", 32'(valid_d), 32'h0);
    check("t1.pcsrc", 32'(pcsrc_d), 32'h0);
    check("t1.count", 32'(taken_count), 32'h0);
    check_all("t1");
    tick();
    reset = 1'b0;

    // beq taken
    load(32'h10220003, 32'h104);
    rd1_d = 5; rd2_d = 5; #1;
    check("t2.pcsrc", 32'(pcsrc_d), 32'h1);
    check("t2.target", pc_branch_d, 32'h110);
    check_all("t2");
    instructionf = 32'h0000_0020; pc_plus_4f = 32'h108;
    tick();
    check("t2.flush_instr", instr_d, 32'h0);
    check("t2.flush_valid", 32'(valid_d), 32'h0);
    check("t2.count", 32'(taken_count), 32'h1);
    check_all("t2b");

    // bne not taken
    load(32'h14220003, 32'h10C);
    rd1_d = 7; rd2_d = 7; #1;
    check("t3.pcsrc", 32'(pcsrc_d), 32'h0);
    check_all("t3");
    load(32'h012A4020, 32'h110);
    check("t3.next_instr", instr_d, 32'h012A4020);
    check("t3.next_valid", 32'(valid_d), 32'h1);

    // backward branch with forwarding
    load(32'h1022FFFF, 32'h200);
    rd1_d = 1; rd2_d = 9; alu_out_m = 9; forward_ad = 1'b1; #1;
    check("t4.pcsrc_fwd", 32'(pcsrc_d), 32'h1);
    check("t4.target", pc_branch_d, 32'h1FC);
    check_all("t4a");
    forward_ad = 1'b0; #1;
    check("t4.pcsrc_nofwd", 32'(pcsrc_d), 32'h0);
    check_all("t4b");

    // jump
    load(32'h08000040, 32'h30000008);
    rd1_d = $urandom(); rd2_d = $urandom(); #1;
    check("t5.target", pc_branch_d, 32'h30000100);
    check("t5.pcsrc", 32'(pcsrc_d), 32'h1);
    check_all("t5");
    load(32'h0000_0020, 32'h3000000C);

    // stalled taken beq
    load(32'h10220003, 32'h400);
    rd1_d = 3; rd2_d = 3; stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6.stall_pcsrc", 32'(pcsrc_d), 32'h0);
      check("t6.stall_instr", instr_d, 32'h10220003);
      check_all("t6s");
      instructionf = $urandom(); pc_plus_4f = $urandom();
      tick();
    end
    stall_d = 1'b0; #1;
    check("t6.release_pcsrc", 32'(pcsrc_d), 32'h1);
    check_all("t6r");
    tick();
    check("t6.after_pcsrc", 32'(pcsrc_d), 32'h0);
    check("t6.after_instr", instr_d, 32'h0);
    check_all("t6f");

    // two more jumps: five redirects in total since the last reset
    for (int i = 0; i < 2; i++) begin
      load(32'h08000100, 32'h500);
      check_all("t6j");
      tick();
    end
    check("t6.count16", 32'(taken_count), 32'd5);
    check("t6.count2", 32'(cnt_w), 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: op = 6'd4;
        1: op = 6'd5;
        2: op = 6'd2;
        default: begin r = $urandom(); op = r[31:26]; end
      endcase
      r = $urandom();
      instructionf = {op, r[25:0]};
      pc_plus_4f   = $urandom();
      stall_d      = ($urandom_range(0, 3) == 0);
      rd1_d        = $urandom();
      rd2_d        = ($urandom_range(0, 1) == 1) ? rd1_d : $urandom();
      alu_out_m    = ($urandom_range(0, 1) == 1) ? rd2_d : $urandom();
      forward_ad   = $urandom_range(0, 1) == 1;
      forward_bd   = $urandom_range(0, 1) == 1;
      #1 check_all("rnd");
      tick();
    end

    // reset while a jump redirect is pending
    load(32'h08000040, 32'h30000008);
    stall_d = 1'b0; #1;
    check_all("pend");
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("pend_rst");
    tick();
    reset = 1'b0; #1;
    check_all("pend_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
